serial_adder: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 14 +
 rtl/serial_adder_full_add_cell.sv | 13 +
 rtl/serial_adder.sv | 86 ++++++++
 tb/tb_serial_adder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared FSM state type and counter sizing for serial_adder
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_adder_full_add_cell.sv
// rtl/serial_adder_full_add_cell.sv - combinational one-bit full adder cell
module full_add_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ c;
    assign co = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial W-bit adder, LSB first, one full-adder cell with registered carry
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout
);

    localparam int CW = cnt_width(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    state_t         state;
    logic [W-1:0]   a_sh;
    logic [W-1:0]   b_sh;
    logic [W-1:0]   s_sh;
    logic           c;
    logic [CW-1:0]  cnt;
    logic           s;
    logic           co;

    full_add_cell u_cell (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .c  (c),
        .s  (s),
        .co (co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            s_sh  <= '0;
            c     <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        c     <= cin;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    s_sh <= {s, s_sh[W-1:1]};
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    c    <= co;
                    cnt  <= cnt + CW'(1);
                    // Final bit: publish the completed word on the same edge it is formed
                    if (cnt == LAST) begin
                        sum   <= {s, s_sh[W-1:1]};
                        cout  <= co;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed self-checking bench for serial_adder (W=8 and W=2)
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    logic       start2;
    logic [1:0] a2;
    logic [1:0] b2;
    logic       cin2;
    logic       busy2;
    logic       done2;
    logic [1:0] sum2;
    logic       cout2;

    int n_checks = 0;
    int n_fails  = 0;
    int lat;
    int busy_cnt;

    always #5 clk = ~clk;

    serial_adder #(.W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    serial_adder #(.W(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one W=8 request and wait (bounded) for done; records latency and busy cycles.
    task automatic run8(input logic [7:0] va, input logic [7:0] vb, input logic vc);
        @(negedge clk);
        a = va; b = vb; cin = vc; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 8'hxx; b = 8'hxx; cin = 1'bx;
        lat = 0; busy_cnt = 0;
        while (!done && lat < 30) begin
            if (busy) busy_cnt++;
            check("busy_done_excl", busy & done, 0);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic run2(input logic [1:0] va, input logic [1:0] vb, input logic vc);
        int t;
        @(negedge clk);
        a2 = va; b2 = vb; cin2 = vc; start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        t = 0;
        while (!done2 && t < 10) begin
            t++;
            @(negedge clk);
        end
        check("w2_latency", t, 2);
        check("w2_result", {cout2, sum2}, {1'b0, va} + {1'b0, vb} + {2'b0, vc});
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic       rc;
        int         gap;
        int         unstable;
        logic [8:0] exp_seq [3];
        logic [7:0] va_seq  [3];
        logic [7:0] vb_seq  [3];
        logic       vc_seq  [3];

        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        rst = 1'b0;

        // Basic add with full carry ripple
        run8(8'hFF, 8'h01, 1'b0);
        check("basic_latency", lat, 8);
        check("basic_busy_cycles", busy_cnt, 8);
        check("basic_sum", sum, 8'h00);
        check("basic_cout", cout, 1);
        @(negedge clk);
        check("basic_done_one_cycle", done, 0);
        check("basic_sum_held", {cout, sum}, 9'h100);

        run8(8'hA5, 8'h5A, 1'b1);
        check("cin_sum", sum, 8'h00);
        check("cin_cout", cout, 1);

        run8(8'h12, 8'h34, 1'b0);
        check("plain_sum", sum, 8'h46);
        check("plain_cout", cout, 0);

        // Start pulsed during RUN must be ignored
        @(negedge clk);
        a = 8'h70; b = 8'h0F; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 30) begin lat++; @(negedge clk); end
        check("ignore_sum", {cout, sum}, 9'h07F);
        gap = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) gap++;
        end
        check("ignore_no_extra_done", gap, 0);

        // Asynchronous reset mid-operation
        @(negedge clk);
        a = 8'h11; b = 8'h22; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_sum", sum, 0);
        check("midrst_cout", cout, 0);
        @(negedge clk);
        rst = 1'b0;
        gap = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) gap++;
        end
        check("midrst_no_stale_done", gap, 0);
        run8(8'h03, 8'h04, 1'b0);
        check("after_rst_latency", lat, 8);
        check("after_rst_sum", {cout, sum}, 9'h007);

        // Back-to-back with start held high
        va_seq = '{8'h10, 8'hF0, 8'h7F};
        vb_seq = '{8'h05, 8'h20, 8'h80};
        vc_seq = '{1'b1, 1'b0, 1'b1};
        exp_seq = '{9'h016, 9'h110, 9'h100};
        @(negedge clk);
        a = va_seq[0]; b = vb_seq[0]; cin = vc_seq[0]; start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            gap = 0; unstable = 0;
            @(negedge clk);
            while (!done && gap < 30) begin
                if (k > 0 && {cout, sum} !== exp_seq[k-1]) unstable++;
                gap++;
                @(negedge clk);
            end
            if (k > 0) begin
                check("b2b_gap_cycles", gap, 9);
                check("b2b_sum_stable", unstable, 0);
            end
            check("b2b_result", {cout, sum}, exp_seq[k]);
            if (k < 2) begin
                a = va_seq[k+1]; b = vb_seq[k+1]; cin = vc_seq[k+1];
            end
        end
        start = 1'b0;
        repeat (3) @(negedge clk);

        // Random sweep at W=8
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            run8(ra, rb, rc);
            check("rand_latency", lat, 8);
            check("rand_result", {cout, sum}, {1'b0, ra} + {1'b0, rb} + {8'b0, rc});
        end

        // Exhaustive at W=2
        for (int i = 0; i < 32; i++) begin
            run2(2'(i), 2'(i >> 2), 1'(i >> 4));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
